// File: rtl/updi_frame_engine.sv
// UPDI frame engine: sends a latched byte frame through a UART TX FIFO,
// optionally checks each single-wire echo, waits for ACK bytes and resends the frame on ACK failure.
module updi_frame_engine #(
    parameter int MAX_DATA_SIZE   = 64,
    parameter int DATA_ADDR_BITS  = $clog2(MAX_DATA_SIZE),
    parameter int ACK_TIMEOUT     = 1024,
    parameter int MAX_RETRIES     = 3,
    parameter int ECHO_CHECK      = 1,
    localparam int RETRY_BITS     = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        start_i,
    output logic                        ready_o,
    input  logic [8*MAX_DATA_SIZE-1:0]  data_i,
    input  logic [DATA_ADDR_BITS-1:0]   data_len_i,
    input  logic [MAX_DATA_SIZE-1:0]    wait_ack_after_i,
    output logic [7:0]                  uart_tx_fifo_data_o,
    output logic                        uart_tx_fifo_wr_en_o,
    input  logic                        uart_tx_fifo_full_i,
    input  logic [7:0]                  uart_rx_fifo_data_i,
    output logic                        uart_rx_fifo_rd_en_o,
    input  logic                        uart_rx_fifo_empty_i,
    output logic                        done_o,
    output logic                        ack_error_o,
    output logic                        timeout_error_o,
    output logic                        echo_error_o,
    output logic [RETRY_BITS-1:0]       retry_count_o
);

    localparam int                      TIMER_BITS  = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TIMER_BITS-1:0]   TIMER_LAST  = TIMER_BITS'(ACK_TIMEOUT - 1);
    localparam logic [RETRY_BITS-1:0]   RETRY_LIMIT = RETRY_BITS'(MAX_RETRIES);
    localparam logic [7:0]              ACK_BYTE    = 8'h40;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SEND     = 3'd1,
        S_ECHO     = 3'd2,
        S_ACK_WAIT = 3'd3,
        S_RETRY    = 3'd4,
        S_FINISH   = 3'd5
    } state_t;

    state_t                      state_q, state_d;
    logic [8*MAX_DATA_SIZE-1:0]  data_q, data_d;
    logic [DATA_ADDR_BITS-1:0]   len_q, len_d;
    logic [MAX_DATA_SIZE-1:0]    wait_q, wait_d;
    logic [DATA_ADDR_BITS-1:0]   idx_q, idx_d;
    logic [TIMER_BITS-1:0]       timer_q, timer_d;
    logic [RETRY_BITS-1:0]       retry_q, retry_d;
    logic                        ack_err_q, ack_err_d;
    logic                        to_err_q, to_err_d;
    logic                        echo_err_q, echo_err_d;

    logic [7:0]                  cur_byte_s;
    logic                        last_byte_s;
    logic [DATA_ADDR_BITS-1:0]   idx_inc_s;
    logic [TIMER_BITS-1:0]       timer_inc_s;
    state_t                      after_byte_state_s;
    logic [DATA_ADDR_BITS-1:0]   after_byte_idx_s;

    assign cur_byte_s  = data_q[{idx_q, 3'b000} +: 8];
    assign idx_inc_s   = idx_q + DATA_ADDR_BITS'(1);
    assign last_byte_s = ({1'b0, idx_q} + (DATA_ADDR_BITS + 1)'(1)) == {1'b0, len_q};
    assign timer_inc_s = timer_q + TIMER_BITS'(1);

    // Where a byte goes once it is written (and echoed): ACK wait, frame end or next byte.
    always_comb begin
        after_byte_idx_s = idx_q;
        if (wait_q[idx_q]) begin
            after_byte_state_s = S_ACK_WAIT;
        end else if (last_byte_s) begin
            after_byte_state_s = S_FINISH;
        end else begin
            after_byte_state_s = S_SEND;
            after_byte_idx_s   = idx_inc_s;
        end
    end

    // Next-state, datapath updates and FIFO strobes.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        len_d      = len_q;
        wait_d     = wait_q;
        idx_d      = idx_q;
        timer_d    = '0;
        retry_d    = retry_q;
        ack_err_d  = ack_err_q;
        to_err_d   = to_err_q;
        echo_err_d = echo_err_q;
        ready_o              = 1'b0;
        done_o               = 1'b0;
        uart_tx_fifo_wr_en_o = 1'b0;
        uart_rx_fifo_rd_en_o = 1'b0;
        uart_tx_fifo_data_o  = cur_byte_s;
        case (state_q)
            S_IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    data_d     = data_i;
                    len_d      = data_len_i;
                    wait_d     = wait_ack_after_i;
                    idx_d      = '0;
                    retry_d    = '0;
                    ack_err_d  = 1'b0;
                    to_err_d   = 1'b0;
                    echo_err_d = 1'b0;
                    state_d    = S_SEND;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEND: begin
                // An empty frame finishes here without touching either FIFO.
                if (len_q == '0) begin
                    state_d = S_FINISH;
                end else if (!uart_tx_fifo_full_i) begin
                    uart_tx_fifo_wr_en_o = 1'b1;
                    if (ECHO_CHECK != 0) begin
                        state_d = S_ECHO;
                    end else begin
                        state_d = after_byte_state_s;
                        idx_d   = after_byte_idx_s;
                    end
                end else begin
                    state_d = S_SEND;
                end
            end
            S_ECHO: begin
                if (!uart_rx_fifo_empty_i) begin
                    uart_rx_fifo_rd_en_o = 1'b1;
                    if (uart_rx_fifo_data_i != cur_byte_s) begin
                        echo_err_d = 1'b1;
                        state_d    = S_FINISH;
                    end else begin
                        state_d = after_byte_state_s;
                        idx_d   = after_byte_idx_s;
                    end
                end else begin
                    state_d = S_ECHO;
                end
            end
            S_ACK_WAIT: begin
                if (!uart_rx_fifo_empty_i) begin
                    uart_rx_fifo_rd_en_o = 1'b1;
                    if (uart_rx_fifo_data_i != ACK_BYTE) begin
                        ack_err_d = 1'b1;
                        state_d   = S_RETRY;
                    end else if (last_byte_s) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_inc_s;
                        state_d = S_SEND;
                    end
                end else begin
                    timer_d = timer_inc_s;
                    if (timer_inc_s == TIMER_LAST) begin
                        to_err_d = 1'b1;
                        state_d  = S_RETRY;
                    end else begin
                        state_d = S_ACK_WAIT;
                    end
                end
            end
            S_RETRY: begin
                if (retry_q < RETRY_LIMIT) begin
                    retry_d   = retry_q + RETRY_BITS'(1);
                    ack_err_d = 1'b0;
                    to_err_d  = 1'b0;
                    idx_d     = '0;
                    state_d   = S_SEND;
                end else begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            data_q     <= '0;
            len_q      <= '0;
            wait_q     <= '0;
            idx_q      <= '0;
            timer_q    <= '0;
            retry_q    <= '0;
            ack_err_q  <= 1'b0;
            to_err_q   <= 1'b0;
            echo_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            len_q      <= len_d;
            wait_q     <= wait_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
            ack_err_q  <= ack_err_d;
            to_err_q   <= to_err_d;
            echo_err_q <= echo_err_d;
        end
    end

    assign ack_error_o     = ack_err_q;
    assign timeout_error_o = to_err_q;
    assign echo_error_o    = echo_err_q;
    assign retry_count_o   = retry_q;

endmodule

// File: tb/tb_updi_frame_engine.sv
// Directed bench for updi_frame_engine: instance A (echo on, one retry) with a FWFT RX FIFO model
// that returns echoes and scripted ACK bytes; instance B (no echo, no retry) for the ACK timeout.
module tb_updi_frame_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] data;
    logic [2:0]  data_len;
    logic [7:0]  wait_ack;
    logic        tx_full;
    logic [7:0]  rx_data;
    logic        rx_empty;

    logic        ready_a, wr_a, rd_a, done_a, ack_err_a, to_err_a, echo_err_a;
    logic [7:0]  tx_data_a;
    logic [0:0]  retry_a;
    logic        ready_b, wr_b, rd_b, done_b, ack_err_b, to_err_b, echo_err_b;
    logic [7:0]  tx_data_b;
    logic [0:0]  retry_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] txlog [$];
    logic [7:0] rxq [$];
    int         done_cnt_a = 0;
    int         wr_idx = 0;
    logic [7:0] echo_xor [8];
    logic       ack_en [8];
    logic [7:0] ack_val [8];

    always #5 clk = ~clk;

    updi_frame_engine #(
        .MAX_DATA_SIZE(8), .ACK_TIMEOUT(16), .MAX_RETRIES(1), .ECHO_CHECK(1)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .ready_o(ready_a),
        .data_i(data), .data_len_i(data_len), .wait_ack_after_i(wait_ack),
        .uart_tx_fifo_data_o(tx_data_a), .uart_tx_fifo_wr_en_o(wr_a), .uart_tx_fifo_full_i(tx_full),
        .uart_rx_fifo_data_i(rx_data), .uart_rx_fifo_rd_en_o(rd_a), .uart_rx_fifo_empty_i(rx_empty),
        .done_o(done_a), .ack_error_o(ack_err_a), .timeout_error_o(to_err_a),
        .echo_error_o(echo_err_a), .retry_count_o(retry_a)
    );

    updi_frame_engine #(
        .MAX_DATA_SIZE(8), .ACK_TIMEOUT(16), .MAX_RETRIES(0), .ECHO_CHECK(0)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .ready_o(ready_b),
        .data_i(data), .data_len_i(data_len), .wait_ack_after_i(wait_ack),
        .uart_tx_fifo_data_o(tx_data_b), .uart_tx_fifo_wr_en_o(wr_b), .uart_tx_fifo_full_i(tx_full),
        .uart_rx_fifo_data_i(8'h00), .uart_rx_fifo_rd_en_o(rd_b), .uart_rx_fifo_empty_i(1'b1),
        .done_o(done_b), .ack_error_o(ack_err_b), .timeout_error_o(to_err_b),
        .echo_error_o(echo_err_b), .retry_count_o(retry_b)
    );

    // TX log, echo/ACK responder and first-word-fall-through RX FIFO for instance A.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxq.delete();
            rx_empty <= 1'b1;
            rx_data  <= 8'h00;
            wr_idx   <= 0;
        end else begin
            if (rd_a && rxq.size() > 0) void'(rxq.pop_front());
            if (wr_a) begin
                txlog.push_back(tx_data_a);
                rxq.push_back(tx_data_a ^ echo_xor[wr_idx]);
                if (ack_en[wr_idx]) rxq.push_back(ack_val[wr_idx]);
            end
            if (start && ready_a) wr_idx <= 0;
            else if (wr_a) wr_idx <= wr_idx + 1;
            if (done_a) done_cnt_a <= done_cnt_a + 1;
            rx_empty <= (rxq.size() == 0);
            rx_data  <= (rxq.size() > 0) ? rxq[0] : 8'h00;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic cfg_clear;
        for (int i = 0; i < 8; i++) begin
            echo_xor[i] = 8'h00;
            ack_en[i]   = 1'b0;
            ack_val[i]  = 8'h00;
        end
    endtask

    // Called at a negedge; returns at the negedge of the first cycle after start is sampled.
    task automatic do_start(input logic [63:0] d, input logic [2:0] len, input logic [7:0] w);
        data = d; data_len = len; wait_ack = w; start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_done_a(input int bound);
        int n = 0;
        while (done_a !== 1'b1 && n < bound) begin
            tick;
            n++;
        end
        checks++;
        if (done_a !== 1'b1) begin
            errors++;
            $display("FAIL done_wait: done=%b after %0d cycles, required 1", done_a, n);
        end
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        tick; tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick; tick;
        checks++;
        if ({ready_a, done_a, wr_a, rd_a, ack_err_a, to_err_a, echo_err_a, retry_a} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_a: got %b, required 10000000",
                     {ready_a, done_a, wr_a, rd_a, ack_err_a, to_err_a, echo_err_a, retry_a});
        end
        checks++;
        if ({ready_b, done_b, wr_b, rd_b, ack_err_b, to_err_b, echo_err_b, retry_b} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_b: got %b, required 10000000",
                     {ready_b, done_b, wr_b, rd_b, ack_err_b, to_err_b, echo_err_b, retry_b});
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_basic;
        int base = txlog.size();
        int dbase = done_cnt_a;
        cfg_clear;
        ack_en[1] = 1'b1; ack_val[1] = 8'h40;
        do_start(64'h3412, 3'd2, 8'b0000_0010);
        checks++;
        if (wr_a !== 1'b1 || tx_data_a !== 8'h12) begin
            errors++;
            $display("FAIL first_write_latency: wr=%b data=%h, required wr=1 data=12", wr_a, tx_data_a);
        end
        wait_done_a(100);
        tick;
        checks++;
        if (ready_a !== 1'b1 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_done: ready=%b done=%b, required 1/0", ready_a, done_a);
        end
        tick; tick;
        checks++;
        if (txlog.size() - base != 2 || txlog[base] !== 8'h12 || txlog[base+1] !== 8'h34) begin
            errors++;
            $display("FAIL basic_writes: count=%0d, required 2 writes 12,34", txlog.size() - base);
        end
        checks++;
        if (done_cnt_a - dbase != 1) begin
            errors++;
            $display("FAIL basic_done_count: got %0d, required 1", done_cnt_a - dbase);
        end
        checks++;
        if ({ack_err_a, to_err_a, echo_err_a, retry_a} !== 4'b0000) begin
            errors++;
            $display("FAIL basic_status: got %b, required 0000", {ack_err_a, to_err_a, echo_err_a, retry_a});
        end
    endtask

    task automatic test_retry;
        int base = txlog.size();
        cfg_clear;
        ack_en[1] = 1'b1; ack_val[1] = 8'h41;
        ack_en[3] = 1'b1; ack_val[3] = 8'h40;
        do_start(64'h3412, 3'd2, 8'b0000_0010);
        wait_done_a(200);
        checks++;
        if (txlog.size() - base != 4 || txlog[base] !== 8'h12 || txlog[base+1] !== 8'h34 ||
            txlog[base+2] !== 8'h12 || txlog[base+3] !== 8'h34) begin
            errors++;
            $display("FAIL retry_writes: count=%0d, required 4 writes 12,34,12,34", txlog.size() - base);
        end
        checks++;
        if ({retry_a, ack_err_a, to_err_a, echo_err_a} !== 4'b1000) begin
            errors++;
            $display("FAIL retry_status: retry/ack/to/echo=%b, required 1000",
                     {retry_a, ack_err_a, to_err_a, echo_err_a});
        end
        tick;
    endtask

    task automatic test_echo;
        int base = txlog.size();
        cfg_clear;
        echo_xor[0] = 8'h01;
        do_start(64'h3412, 3'd2, 8'b0000_0010);
        wait_done_a(100);
        checks++;
        if ({echo_err_a, ack_err_a, to_err_a, retry_a} !== 4'b1000) begin
            errors++;
            $display("FAIL echo_status: echo/ack/to/retry=%b, required 1000",
                     {echo_err_a, ack_err_a, to_err_a, retry_a});
        end
        tick; tick;
        checks++;
        if (txlog.size() - base != 1 || txlog[base] !== 8'h12) begin
            errors++;
            $display("FAIL echo_writes: count=%0d, required 1 write of 12", txlog.size() - base);
        end
    endtask

    task automatic test_tx_full;
        int   base = txlog.size();
        logic any_wr = 1'b0;
        cfg_clear;
        tx_full = 1'b1;
        data = 64'h12; data_len = 3'd1; wait_ack = 8'h00; start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            start = 1'b0;
            any_wr = any_wr | wr_a;
        end
        checks++;
        if (any_wr !== 1'b0) begin
            errors++;
            $display("FAIL full_hold: wr_en seen=%b while full, required 0", any_wr);
        end
        tx_full = 1'b0;
        #1;
        checks++;
        if (wr_a !== 1'b1 || tx_data_a !== 8'h12) begin
            errors++;
            $display("FAIL full_release: wr=%b data=%h, required wr=1 data=12", wr_a, tx_data_a);
        end
        tick;
        wait_done_a(100);
        tick;
        checks++;
        if (txlog.size() - base != 1 || echo_err_a !== 1'b0) begin
            errors++;
            $display("FAIL full_writes: count=%0d echo_err=%b, required 1/0", txlog.size() - base, echo_err_a);
        end
    endtask

    task automatic test_zero_len;
        int base = txlog.size();
        cfg_clear;
        do_start(64'h0, 3'd0, 8'h00);
        checks++;
        if (done_a !== 1'b0 || wr_a !== 1'b0 || rd_a !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_c1: done=%b wr=%b rd=%b, required 000", done_a, wr_a, rd_a);
        end
        tick;
        checks++;
        if (done_a !== 1'b1 || wr_a !== 1'b0 || rd_a !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_c2: done=%b wr=%b rd=%b, required 100", done_a, wr_a, rd_a);
        end
        tick;
        checks++;
        if (ready_a !== 1'b1 || txlog.size() != base) begin
            errors++;
            $display("FAIL zero_len_end: ready=%b writes=%0d, required 1/0", ready_a, txlog.size() - base);
        end
    endtask

    task automatic test_back_to_back;
        int base = txlog.size();
        cfg_clear;
        ack_en[1] = 1'b1; ack_val[1] = 8'h40;
        do_start(64'h3412, 3'd2, 8'b0000_0010);
        data = 64'hAA; data_len = 3'd1; wait_ack = 8'h00; start = 1'b1;
        tick;
        start = 1'b0;
        wait_done_a(100);
        tick;
        checks++;
        if (ready_a !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: ready=%b, required 1", ready_a);
        end
        cfg_clear;
        do_start(64'h5A, 3'd1, 8'h00);
        checks++;
        if (wr_a !== 1'b1 || tx_data_a !== 8'h5A) begin
            errors++;
            $display("FAIL b2b_second_write: wr=%b data=%h, required wr=1 data=5a", wr_a, tx_data_a);
        end
        wait_done_a(100);
        tick;
        checks++;
        if (txlog.size() - base != 3 || txlog[base] !== 8'h12 || txlog[base+1] !== 8'h34 ||
            txlog[base+2] !== 8'h5A) begin
            errors++;
            $display("FAIL b2b_writes: count=%0d, required 3 writes 12,34,5a", txlog.size() - base);
        end
    endtask

    task automatic test_reset_abort;
        int   base;
        int   dbase;
        logic any_done = 1'b0;
        cfg_clear;
        do_start(64'h12, 3'd1, 8'b0000_0001);
        for (int i = 0; i < 5; i++) tick;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ready_a !== 1'b1 || wr_a !== 1'b0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL abort_in_reset: ready=%b wr=%b done=%b, required 100", ready_a, wr_a, done_a);
        end
        base = txlog.size();
        dbase = done_cnt_a;
        tick; tick;
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick;
            any_done = any_done | done_a;
        end
        checks++;
        if (txlog.size() != base || done_cnt_a != dbase || any_done !== 1'b0 || ready_a !== 1'b1) begin
            errors++;
            $display("FAIL abort_quiet: writes=%0d dones=%0d ready=%b, required 0/0/1",
                     txlog.size() - base, done_cnt_a - dbase, ready_a);
        end
        test_basic;
    endtask

    task automatic test_timeout;
        int n = 0;
        cfg_clear;
        apply_reset;
        do_start(64'h55, 3'd1, 8'b0000_0001);
        checks++;
        if (wr_b !== 1'b1 || tx_data_b !== 8'h55) begin
            errors++;
            $display("FAIL timeout_write_b: wr=%b data=%h, required wr=1 data=55", wr_b, tx_data_b);
        end
        tick;
        while (done_b !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL timeout_latency: done %0d cycles after ACK_WAIT entry, required 16", n);
        end
        checks++;
        if ({to_err_b, ack_err_b, echo_err_b, retry_b} !== 4'b1000) begin
            errors++;
            $display("FAIL timeout_status_b: to/ack/echo/retry=%b, required 1000",
                     {to_err_b, ack_err_b, echo_err_b, retry_b});
        end
        wait_done_a(100);
        checks++;
        if ({to_err_a, ack_err_a, retry_a} !== 3'b101) begin
            errors++;
            $display("FAIL retry_exhausted_a: to/ack/retry=%b, required 101", {to_err_a, ack_err_a, retry_a});
        end
        tick;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; data = '0; data_len = '0; wait_ack = '0; tx_full = 1'b0;
        cfg_clear;
        test_reset;
        test_basic;
        test_retry;
        test_echo;
        test_tx_full;
        test_zero_len;
        test_back_to_back;
        test_reset_abort;
        test_timeout;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
